// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the CPU fetch (IF) and data (DM) ports.
// A grant FSM latches the winning request, holds the memory for WAIT_CYCLES, then pulses ready.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_dm_q, last_dm_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm_s;

  // DM normally wins; IF wins when DM had the previous grant so neither port starves.
  assign grant_dm_s = dm_req && !(last_dm_q && if_req);

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_dm_s) begin
          state_d     = BUSY_DM;
          cnt_d       = CNT_LOAD;
          last_dm_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d     = BUSY_IF;
          cnt_d       = CNT_LOAD;
          last_dm_d   = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Last access cycle: mem_rdata is valid now; the memory bus is released for DONE.
          state_d     = DONE;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = {ADDR_W{1'b0}};
          mem_wdata_d = {DATA_W{1'b0}};
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = CNT_ZERO;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_wdata_d = {DATA_W{1'b0}};
      end
    endcase
  end

  // FSM state and all output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      last_dm_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with WAIT_CYCLES=2.
// The memory model returns valid data only in the second consecutive mem_en cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_err;
  int en_cnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: counts consecutive enabled cycles; data is valid only in the last one.
  always @(posedge clk or negedge reset) begin
    if (!reset) en_cnt <= 0;
    else        en_cnt <= mem_en ? en_cnt + 1 : 0;
  end

  assign mem_rdata = (mem_en && en_cnt == 1) ?
                     ((mem_addr == 32'h4) ? 32'h2010_0005 : (mem_addr ^ 32'h5A5A_0000)) :
                     32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0;
    #12;
    if ({if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {132{1'b0}}) begin
      n_err++;
      $display("FAIL reset_outputs got ctrl=%b%b%b%b addr=%h exp all zero",
               mem_en, mem_we, if_ready, dm_ready, mem_addr);
    end
    n_vec++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_lone_if();
    logic [3:0] exp_ctrl[4];
    logic [31:0] exp_addr[4];
    exp_ctrl = '{4'b1000, 4'b1000, 4'b0010, 4'b0000};
    exp_addr = '{32'h4, 32'h4, 32'h0, 32'h0};
    if_addr = 32'h4; if_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({mem_en, mem_we, if_ready, dm_ready} !== exp_ctrl[c]) begin
        n_err++;
        $display("FAIL lone_if_ctrl cycle%0d got=%b exp=%b", c + 1, {mem_en, mem_we, if_ready, dm_ready}, exp_ctrl[c]);
      end
      n_vec++;
      if (mem_addr !== exp_addr[c]) begin
        n_err++;
        $display("FAIL lone_if_addr cycle%0d got=%h exp=%h", c + 1, mem_addr, exp_addr[c]);
      end
      n_vec++;
      if (if_ready) if_req = 1'b0;
    end
    if (if_rdata !== 32'h2010_0005) begin
      n_err++;
      $display("FAIL lone_if_rdata got=%h exp=%h", if_rdata, 32'h2010_0005);
    end
    n_vec++;
  endtask

  task automatic test_contention();
    logic exp_dm, exp_if;
    logic [31:0] exp_addr;
    tick();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    dm_addr = 32'h100; if_addr = 32'h200; dm_req = 1'b1; if_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_dm = (c == 3);
      exp_if = (c == 7);
      exp_addr = (c == 1 || c == 2) ? 32'h100 : ((c == 5 || c == 6) ? 32'h200 : 32'h0);
      if ({dm_ready, if_ready} !== {exp_dm, exp_if}) begin
        n_err++;
        $display("FAIL contention_ready cycle%0d got dm/if=%b%b exp=%b%b", c, dm_ready, if_ready, exp_dm, exp_if);
      end
      n_vec++;
      if (mem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL contention_addr cycle%0d got=%h exp=%h", c, mem_addr, exp_addr);
      end
      n_vec++;
      if (dm_ready) dm_req = 1'b0;
      if (if_ready) if_req = 1'b0;
    end
    if (dm_rdata !== 32'h5A5A_0100 || if_rdata !== 32'h5A5A_0200) begin
      n_err++;
      $display("FAIL contention_rdata got dm=%h if=%h exp dm=%h if=%h", dm_rdata, if_rdata, 32'h5A5A_0100, 32'h5A5A_0200);
    end
    n_vec++;
  endtask

  task automatic test_fairness();
    logic exp_dm, exp_if;
    dm_addr = 32'h300; if_addr = 32'h400; dm_req = 1'b1; if_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp_dm = (c == 3 || c == 11);
      exp_if = (c == 7 || c == 15);
      if ({dm_ready, if_ready} !== {exp_dm, exp_if}) begin
        n_err++;
        $display("FAIL fairness_order cycle%0d got dm/if=%b%b exp=%b%b", c, dm_ready, if_ready, exp_dm, exp_if);
      end
      n_vec++;
      if (dm_ready && dm_rdata !== 32'h5A5A_0300) begin
        n_err++;
        $display("FAIL fairness_dm_rdata cycle%0d got=%h exp=%h", c, dm_rdata, 32'h5A5A_0300);
      end
      if (if_ready && if_rdata !== 32'h5A5A_0400) begin
        n_err++;
        $display("FAIL fairness_if_rdata cycle%0d got=%h exp=%h", c, if_rdata, 32'h5A5A_0400);
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_dm_write();
    logic [3:0] exp_ctrl[4];
    logic [31:0] exp_wdata[4];
    exp_ctrl  = '{4'b1100, 4'b1100, 4'b0001, 4'b0000};
    exp_wdata = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0};
    dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({mem_en, mem_we, if_ready, dm_ready} !== exp_ctrl[c]) begin
        n_err++;
        $display("FAIL dm_write_ctrl cycle%0d got=%b exp=%b", c + 1, {mem_en, mem_we, if_ready, dm_ready}, exp_ctrl[c]);
      end
      n_vec++;
      if (mem_wdata !== exp_wdata[c]) begin
        n_err++;
        $display("FAIL dm_write_wdata cycle%0d got=%h exp=%h", c + 1, mem_wdata, exp_wdata[c]);
      end
      n_vec++;
      if (dm_ready) dm_req = 1'b0;
    end
    if (dm_rdata !== 32'h5A5A_0300) begin
      n_err++;
      $display("FAIL dm_write_rdata_kept got=%h exp=%h", dm_rdata, 32'h5A5A_0300);
    end
    n_vec++;
    dm_we = 1'b0; dm_wdata = 32'h0;
  endtask

  task automatic test_addr_hold();
    dm_addr = 32'h10; dm_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) dm_addr = 32'h20;
      if (c <= 2 && (mem_addr !== 32'h10 || mem_en !== 1'b1)) begin
        n_err++;
        $display("FAIL addr_hold cycle%0d got addr=%h en=%b exp addr=%h en=1", c, mem_addr, mem_en, 32'h10);
      end
      if (c <= 2) n_vec++;
      if (dm_ready) dm_req = 1'b0;
    end
    if (dm_rdata !== 32'h5A5A_0010) begin
      n_err++;
      $display("FAIL addr_hold_rdata got=%h exp=%h", dm_rdata, 32'h5A5A_0010);
    end
    n_vec++;
  endtask

  task automatic test_req_drop();
    if_addr = 32'h44; if_req = 1'b1;
    tick();
    if_req = 1'b0;
    tick();
    tick();
    if (if_ready !== 1'b1 || if_rdata !== 32'h5A5A_0044) begin
      n_err++;
      $display("FAIL req_drop got ready=%b rdata=%h exp ready=1 rdata=%h", if_ready, if_rdata, 32'h5A5A_0044);
    end
    n_vec++;
    tick();
    if ({mem_en, if_ready, dm_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL req_drop_idle got=%b exp=%b", {mem_en, if_ready, dm_ready}, 3'b000);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    if_addr = 32'h8; if_req = 1'b1;
    tick();
    if (mem_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy got en=%b exp=1", mem_en);
    end
    n_vec++;
    #2;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      if ({if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {132{1'b0}}) begin
        n_err++;
        $display("FAIL reset_mid_zero step%0d got ctrl=%b%b%b%b addr=%h exp all zero",
                 c, mem_en, mem_we, if_ready, dm_ready, mem_addr);
      end
      n_vec++;
      tick();
    end
    if_req = 1'b0;
    reset = 1'b1;
    tick();
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_idle got=%b exp=%b", {mem_en, mem_we, if_ready, dm_ready}, 4'b0000);
    end
    n_vec++;
    if_addr = 32'h4; if_req = 1'b1;
    tick();
    tick();
    tick();
    if (if_ready !== 1'b1 || if_rdata !== 32'h2010_0005) begin
      n_err++;
      $display("FAIL reset_mid_fresh got ready=%b rdata=%h exp ready=1 rdata=%h", if_ready, if_rdata, 32'h2010_0005);
    end
    n_vec++;
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_lone_if();
    test_contention();
    test_fairness();
    test_dm_write();
    test_addr_hold();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
